mbox_fifo_client: RTL and testbench
===================================

# mbox_fifo_client

Parametrised next-generation mailbox client: bridges an APB register bank to the word-stream mailbox link, adding TX/RX FIFOs of configurable depth and width, a DONE request that defers until the TX FIFO drains, an abort handshake FSM with timeout, and interrupt enable/pending registers. It sits between the CPU's APB peripheral bus and the mailbox fabric, single clock domain; no CDC inside.

## Interface
- DW, 32: link and data-register width (8..32)
- TX_DEPTH, 8: TX FIFO entries (2..128, power of two)
- RX_DEPTH, 8: RX FIFO entries (2..128, power of two)
- AW, 12: APB address width
- ABORT_TO, 1024: abort-ack timeout in cycles; 0 disables
- pclk  in  1  sole clock; all logic rising-edge
- reset  in  1  asynchronous, active-high reset
- psel, penable, pwrite  in  1  APB control
- paddr  in  AW  byte address; bits [4:2] decode, rest ignored
- pwdata  in  32  write data
- prdata  out  32  read data, valid in access phase
- pready  out  1  tied 1 (zero wait)
- pslverr  out  1  tied 0
- mbox_w_dat  out  DW  TX FIFO head
- mbox_w_valid  out  1  TX FIFO non-empty and FSM IDLE
- mbox_w_ready  in  1  remote accepts word
- mbox_w_done  out  1  one-cycle end-of-packet pulse
- mbox_r_dat  in  DW  incoming word
- mbox_r_valid  in  1  incoming word valid
- mbox_r_ready  out  1  RX FIFO not full and FSM IDLE
- mbox_r_done  in  1  remote end-of-packet pulse
- mbox_w_abort  out  1  local abort request / ack
- mbox_r_abort  in  1  remote abort request / ack
- irq_available, irq_abort_init, irq_abort_done, irq_error  out  1  registered level, pending & enable

## Operation
- Access = psel & penable; writes/pops take effect in the access cycle.
- 0x00 WDATA (W): push pwdata[DW-1:0]; if TX full (count before same-cycle pop) drop and set tx_err.
- 0x04 RDATA (R): return RX head zero-extended and pop; if empty return 0, set rx_err.
- 0x08 STATUS (R; bits 3..5 W1C): [0] rx_avail, [1] tx_free, [2] abort_in_progress, [3] abort_ack, [4] rx_err, [5] tx_err, [15:8] rx_level, [23:16] tx_level.
- 0x0C INT_EN (RW, [3:0]); 0x10 INT_PEND (R, W1C, [3:0]): bit0 available, bit1 abort_init, bit2 abort_done, bit3 error.
- 0x18 ABORT (W, any data): start local abort. 0x1C DONE (W): set done_req.
- Unmapped reads return 0; unmapped writes ignored.
- done_req: mbox_w_done pulses the first cycle done_req=1, TX empty, FSM IDLE; then clears. Abort clears it.
- available pends on mbox_r_done; error pends on any tx_err/rx_err set event or abort timeout. Set wins over same-cycle W1C.
- Abort FSM: IDLE, WAIT_ACK.
  - IDLE + ABORT write: flush both FIFOs, clear done_req, mbox_w_abort=1, load timeout counter, go WAIT_ACK.
  - IDLE + mbox_r_abort (remote request): flush, mbox_w_abort=1 for exactly one cycle as ack, pend abort_init, stay IDLE.
  - IDLE + both same cycle: treat as completed handshake: flush, pend abort_done, set abort_ack, no ack pulse.
  - WAIT_ACK: mbox_w_abort held 1; mbox_r_abort -> pend abort_done, set abort_ack, IDLE. Counter reaching 0 (ABORT_TO>0) -> pend error, IDLE. APB ABORT writes ignored.
- abort_in_progress = (state==WAIT_ACK). Link valid/ready forced 0 outside IDLE.

## Timing
- Reset: FIFOs empty, all sticky/pending/enable bits 0, done_req 0, FSM IDLE, every output 0 except pready=1 and mbox_r_ready=1 one cycle after reset release (FIFO empty).
- WDATA write in cycle N -> mbox_w_valid in N+1. Link transfer when valid&ready; next head presented in following cycle.
- mbox_r_valid&ready in N -> rx_avail and RDATA readable in N+1.
- Flush takes effect the cycle after the triggering event; pushes in the trigger cycle are discarded.
- Pending/status bits update the cycle after the event; irq_* one cycle after pending.
- TX and RX support simultaneous push and pop each cycle; levels stay constant.

## Structure
- Package mbox_pkg: register offset localparams, INT bit indices, abort_state_e enum, STATUS bit positions.
- Sub-module mbox_sync_fifo (DW, DEPTH; push, pop, flush, head, count, full, empty), instantiated for TX and RX.
- Top holds APB decode, sticky/pending logic, done_req, abort FSM and timeout counter.

## Test plan
- Write 0x11,0x22,0x33 to WDATA with w_ready=1 -> three valid&ready beats in order, tx_level returns 0; DONE written mid-stream -> w_done pulses only after third beat.
- TX_DEPTH=8, w_ready=0, nine writes -> tx_level=8, tx_err=1, INT_PEND bit3=1, irq_error=1 iff INT_EN bit3=1; 9th word never sent.
- Read RDATA on empty RX -> prdata=0, rx_err=1; W1C 0x10 to STATUS -> rx_err=0.
- Remote sends 4 words + r_done -> rx_level=4, INT_PEND bit0=1; four RDATA reads return words in order.
- ABORT write with TX holding 3 words -> FIFO flushed, w_abort high until r_abort after 5 cycles, abort_done pending, abort_ack=1; repeat with no r_abort, ABORT_TO=16 -> IDLE after 16 cycles, error pending.
- r_abort in IDLE -> one-cycle w_abort ack, abort_init pending; r_abort coincident with ABORT write -> no ack pulse, abort_done pending; reset asserted in WAIT_ACK -> w_abort 0 immediately.

Source files
------------

// File: rtl/mbox_pkg.sv
// mbox_pkg
//   Shared definitions for the mailbox FIFO client: APB register word
//   offsets (paddr[4:2]), interrupt bit indices, STATUS bit positions and
//   the abort handshake state encoding.
package mbox_pkg;

  // Register word index = paddr[4:2]
  localparam logic [2:0] REG_WDATA    = 3'd0;  // 0x00
  localparam logic [2:0] REG_RDATA    = 3'd1;  // 0x04
  localparam logic [2:0] REG_STATUS   = 3'd2;  // 0x08
  localparam logic [2:0] REG_INT_EN   = 3'd3;  // 0x0C
  localparam logic [2:0] REG_INT_PEND = 3'd4;  // 0x10
  localparam logic [2:0] REG_ABORT    = 3'd6;  // 0x18
  localparam logic [2:0] REG_DONE     = 3'd7;  // 0x1C

  // INT_EN / INT_PEND bit indices
  localparam int INT_AVAIL      = 0;
  localparam int INT_ABORT_INIT = 1;
  localparam int INT_ABORT_DONE = 2;
  localparam int INT_ERROR      = 3;

  // STATUS bit positions
  localparam int ST_RX_AVAIL    = 0;
  localparam int ST_TX_FREE     = 1;
  localparam int ST_ABORT_BUSY  = 2;
  localparam int ST_ABORT_ACK   = 3;
  localparam int ST_RX_ERR      = 4;
  localparam int ST_TX_ERR      = 5;
  localparam int ST_RX_LVL_LSB  = 8;
  localparam int ST_TX_LVL_LSB  = 16;

  typedef enum logic {
    ABORT_IDLE     = 1'b0,
    ABORT_WAIT_ACK = 1'b1
  } abort_state_e;

endpackage

// File: rtl/mbox_sync_fifo.sv
// mbox_sync_fifo
//   Single-clock FIFO with synchronous flush, used for the mailbox TX and
//   RX paths. Push and pop may occur in the same cycle. A push while full
//   is dropped (fullness judged before any same-cycle pop); a pop while
//   empty is ignored. Flush overrides push and pop in the same cycle.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset
//   i_push, i_data    write request and data
//   i_pop             read request (advances head)
//   i_flush           discard all contents
//   o_head            current head word (undefined when empty)
//   o_count           number of stored entries (0..DEPTH)
//   o_full, o_empty   occupancy flags
module mbox_sync_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic                     i_flush,
  input  logic [DW-1:0]            i_data,
  output logic [DW-1:0]            o_head,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_rd_ptr;
  logic [PW-1:0] r_wr_ptr;
  logic [PW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == (PW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_push_ok = i_push & ~o_full;
  assign w_pop_ok  = i_pop & ~o_empty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop_ok);
    end
  end

  // NOTE: storage has no reset; occupancy is tracked by the pointers, so
  // stale contents are never observed and the array can map to plain RAM.
  always_ff @(posedge i_clk) begin
    if (w_push_ok && !i_flush) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/mbox_fifo_client.sv
// mbox_fifo_client
//   APB-attached mailbox client. Bridges a register bank to the word-stream
//   mailbox link through TX/RX FIFOs, defers DONE until TX drains, runs an
//   abort handshake with optional timeout, and raises level interrupts.
// Ports:
//   pclk, reset                      clock, asynchronous active-high reset
//   psel/penable/pwrite/paddr/pwdata APB request (zero wait states)
//   prdata/pready/pslverr            APB response
//   mbox_w_*                         outgoing link (data, valid, ready, done)
//   mbox_r_*                         incoming link (data, valid, ready, done)
//   mbox_w_abort / mbox_r_abort      abort request/ack, local and remote
//   irq_*                            registered pending & enable
module mbox_fifo_client
  import mbox_pkg::*;
#(
  parameter int DW       = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8,
  parameter int AW       = 12,
  parameter int ABORT_TO = 1024
) (
  input  logic          pclk,
  input  logic          reset,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [AW-1:0] paddr,
  input  logic [31:0]   pwdata,
  output logic [31:0]   prdata,
  output logic          pready,
  output logic          pslverr,
  output logic [DW-1:0] mbox_w_dat,
  output logic          mbox_w_valid,
  input  logic          mbox_w_ready,
  output logic          mbox_w_done,
  input  logic [DW-1:0] mbox_r_dat,
  input  logic          mbox_r_valid,
  output logic          mbox_r_ready,
  input  logic          mbox_r_done,
  output logic          mbox_w_abort,
  input  logic          mbox_r_abort,
  output logic          irq_available,
  output logic          irq_abort_init,
  output logic          irq_abort_done,
  output logic          irq_error
);

  localparam int TW  = (ABORT_TO > 1) ? $clog2(ABORT_TO + 1) : 1;
  localparam int TCW = $clog2(TX_DEPTH) + 1;
  localparam int RCW = $clog2(RX_DEPTH) + 1;

  abort_state_e    r_state;
  logic [TW-1:0]   r_timer;
  logic            r_w_abort;
  logic            r_done_req;
  logic            r_rx_err, r_tx_err, r_abort_ack;
  logic [3:0]      r_int_en, r_pend, r_irq;

  logic            w_wr, w_rd, w_idle;
  logic [2:0]      w_idx;
  logic            w_wdata_wr, w_rdata_rd, w_status_wr, w_abort_wr;
  logic            w_flush, w_timeout, w_ack_done, w_remote_req;
  logic            w_tx_err_set, w_rx_err_set, w_tx_pop, w_rx_push;
  logic [3:0]      w_pend_set, w_pend_clr;
  logic [31:0]     w_status;
  logic [DW-1:0]   w_tx_head, w_rx_head;
  logic [TCW-1:0]  w_tx_count;
  logic [RCW-1:0]  w_rx_count;
  logic            w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
  logic            w_unused;

  assign w_wr        = psel & penable & pwrite;
  assign w_rd        = psel & penable & ~pwrite;
  assign w_idx       = paddr[4:2];
  assign w_idle      = (r_state == ABORT_IDLE);
  assign w_wdata_wr  = w_wr && (w_idx == REG_WDATA);
  assign w_rdata_rd  = w_rd && (w_idx == REG_RDATA);
  assign w_status_wr = w_wr && (w_idx == REG_STATUS);
  // ABORT writes only count in IDLE; WAIT_ACK ignores them.
  assign w_abort_wr  = w_wr && (w_idx == REG_ABORT) && w_idle;
  assign w_unused    = ^{paddr, pwdata};

  // Any abort trigger seen in IDLE flushes both FIFOs.
  assign w_flush      = w_idle & (w_abort_wr | mbox_r_abort);
  assign w_remote_req = w_idle & mbox_r_abort & ~w_abort_wr;
  // Remote ack in WAIT_ACK, or a crossing request treated as a completed handshake.
  assign w_ack_done   = mbox_r_abort & (~w_idle | w_abort_wr);
  assign w_timeout    = (ABORT_TO != 0) && !w_idle && !mbox_r_abort &&
                        (r_timer == TW'(1));

  assign w_tx_err_set = w_wdata_wr & w_tx_full;
  assign w_rx_err_set = w_rdata_rd & w_rx_empty;

  assign mbox_w_valid = ~w_tx_empty & w_idle;
  assign mbox_w_dat   = mbox_w_valid ? w_tx_head : '0;
  assign mbox_r_ready = ~w_rx_full & w_idle;
  assign mbox_w_done  = r_done_req & w_tx_empty & w_idle;
  assign mbox_w_abort = r_w_abort;
  assign w_tx_pop     = mbox_w_valid & mbox_w_ready;
  assign w_rx_push    = mbox_r_valid & mbox_r_ready;

  assign pready  = 1'b1;
  assign pslverr = 1'b0;

  mbox_sync_fifo #(.DW(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .i_clk  (pclk),
    .i_rst  (reset),
    .i_push (w_wdata_wr),
    .i_pop  (w_tx_pop),
    .i_flush(w_flush),
    .i_data (pwdata[DW-1:0]),
    .o_head (w_tx_head),
    .o_count(w_tx_count),
    .o_full (w_tx_full),
    .o_empty(w_tx_empty)
  );

  mbox_sync_fifo #(.DW(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .i_clk  (pclk),
    .i_rst  (reset),
    .i_push (w_rx_push),
    .i_pop  (w_rdata_rd),
    .i_flush(w_flush),
    .i_data (mbox_r_dat),
    .o_head (w_rx_head),
    .o_count(w_rx_count),
    .o_full (w_rx_full),
    .o_empty(w_rx_empty)
  );

  // Abort FSM. mbox_w_abort is held through WAIT_ACK, or pulsed for one
  // cycle as the ack to a remote request.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_state   <= ABORT_IDLE;
      r_timer   <= '0;
      r_w_abort <= 1'b0;
    end else begin
      case (r_state)
        ABORT_IDLE: begin
          if (w_abort_wr && !mbox_r_abort) begin
            r_state   <= ABORT_WAIT_ACK;
            r_timer   <= TW'(ABORT_TO);
            r_w_abort <= 1'b1;
          end else begin
            r_w_abort <= w_remote_req;
          end
        end
        ABORT_WAIT_ACK: begin
          if (mbox_r_abort || w_timeout) begin
            r_state   <= ABORT_IDLE;
            r_w_abort <= 1'b0;
          end else begin
            r_timer <= r_timer - TW'(1);
          end
        end
        default: r_state <= ABORT_IDLE;
      endcase
    end
  end

  assign w_pend_set = {w_tx_err_set | w_rx_err_set | w_timeout,
                       w_ack_done, w_remote_req, mbox_r_done};
  assign w_pend_clr = (w_wr && (w_idx == REG_INT_PEND)) ? pwdata[3:0] : 4'b0;

  // Sticky and pending bits: a set event wins over a same-cycle W1C.
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      r_rx_err    <= 1'b0;
      r_tx_err    <= 1'b0;
      r_abort_ack <= 1'b0;
      r_int_en    <= '0;
      r_pend      <= '0;
      r_irq       <= '0;
      r_done_req  <= 1'b0;
    end else begin
      r_rx_err    <= w_rx_err_set | (r_rx_err & ~(w_status_wr & pwdata[ST_RX_ERR]));
      r_tx_err    <= w_tx_err_set | (r_tx_err & ~(w_status_wr & pwdata[ST_TX_ERR]));
      r_abort_ack <= w_ack_done | (r_abort_ack & ~(w_status_wr & pwdata[ST_ABORT_ACK]));
      r_pend      <= w_pend_set | (r_pend & ~w_pend_clr);
      r_irq       <= r_pend & r_int_en;
      if (w_wr && (w_idx == REG_INT_EN)) r_int_en <= pwdata[3:0];
      if (w_flush)                                   r_done_req <= 1'b0;
      else if (w_wr && (w_idx == REG_DONE))          r_done_req <= 1'b1;
      else if (mbox_w_done)                          r_done_req <= 1'b0;
    end
  end

  assign irq_available  = r_irq[INT_AVAIL];
  assign irq_abort_init = r_irq[INT_ABORT_INIT];
  assign irq_abort_done = r_irq[INT_ABORT_DONE];
  assign irq_error      = r_irq[INT_ERROR];

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_status                            = '0;
    w_status[ST_RX_AVAIL]               = ~w_rx_empty;
    w_status[ST_TX_FREE]                = ~w_tx_full;
    w_status[ST_ABORT_BUSY]             = ~w_idle;
    w_status[ST_ABORT_ACK]              = r_abort_ack;
    w_status[ST_RX_ERR]                 = r_rx_err;
    w_status[ST_TX_ERR]                 = r_tx_err;
    w_status[ST_RX_LVL_LSB +: 8]        = 8'(w_rx_count);
    w_status[ST_TX_LVL_LSB +: 8]        = 8'(w_tx_count);
  end

  always_comb begin
    prdata = '0;
    if (w_rd) begin
      case (w_idx)
        REG_RDATA:    if (!w_rx_empty) prdata[DW-1:0] = w_rx_head;
        REG_STATUS:   prdata = w_status;
        REG_INT_EN:   prdata[3:0] = r_int_en;
        REG_INT_PEND: prdata[3:0] = r_pend;
        default:      prdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mbox_fifo_client.sv
// tb_mbox_fifo_client
//   Directed bench for mbox_fifo_client (DW=32, depths 8, ABORT_TO=16).
//   Inputs change on the falling edge; outputs are sampled there or #1 later.
module tb_mbox_fifo_client;

  localparam logic [11:0] A_WDATA    = 12'h000;
  localparam logic [11:0] A_RDATA    = 12'h004;
  localparam logic [11:0] A_STATUS   = 12'h008;
  localparam logic [11:0] A_INT_EN   = 12'h00C;
  localparam logic [11:0] A_INT_PEND = 12'h010;
  localparam logic [11:0] A_ABORT    = 12'h018;
  localparam logic [11:0] A_DONE     = 12'h01C;

  logic        pclk = 1'b0;
  logic        reset = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [11:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] mbox_w_dat;
  logic        mbox_w_valid, mbox_w_done, mbox_w_abort, mbox_r_ready;
  logic        mbox_w_ready = 1'b0;
  logic [31:0] mbox_r_dat = '0;
  logic        mbox_r_valid = 1'b0, mbox_r_done = 1'b0, mbox_r_abort = 1'b0;
  logic        irq_available, irq_abort_init, irq_abort_done, irq_error;

  int checks = 0;
  int failures = 0;

  mbox_fifo_client #(
    .DW(32), .TX_DEPTH(8), .RX_DEPTH(8), .AW(12), .ABORT_TO(16)
  ) dut (
    .pclk(pclk), .reset(reset), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr),
    .mbox_w_dat(mbox_w_dat), .mbox_w_valid(mbox_w_valid),
    .mbox_w_ready(mbox_w_ready), .mbox_w_done(mbox_w_done),
    .mbox_r_dat(mbox_r_dat), .mbox_r_valid(mbox_r_valid),
    .mbox_r_ready(mbox_r_ready), .mbox_r_done(mbox_r_done),
    .mbox_w_abort(mbox_w_abort), .mbox_r_abort(mbox_r_abort),
    .irq_available(irq_available), .irq_abort_init(irq_abort_init),
    .irq_abort_done(irq_abort_done), .irq_error(irq_error)
  );

  always #5 pclk = ~pclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Returns at the falling edge following the access cycle.
  task automatic apb_write(input logic [11:0] a, input logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [11:0] a, output logic [31:0] d);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge pclk);
    penable = 1'b1;
    #1 d = prdata;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    repeat (3) @(negedge pclk);
    reset = 1'b0;
    @(negedge pclk);
    checks++;
    if ({pready, pslverr, mbox_w_valid, mbox_w_done, mbox_w_abort, mbox_r_ready} !== 6'b100001) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected 100001",
               {pready, pslverr, mbox_w_valid, mbox_w_done, mbox_w_abort, mbox_r_ready});
    end
    checks++;
    if ({irq_available, irq_abort_init, irq_abort_done, irq_error, prdata, mbox_w_dat} !== '0) begin
      failures++;
      $display("FAIL reset_irq_data: irq=%b prdata=%h wdat=%h expected all zero",
               {irq_available, irq_abort_init, irq_abort_done, irq_error}, prdata, mbox_w_dat);
    end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0002) begin
      failures++;
      $display("FAIL reset_status: got %h expected 00000002", d);
    end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL reset_pend: got %h expected 0", d); end
  endtask

  task automatic test_tx_stream();
    logic [31:0] d;
    logic [31:0] exp_w [3] = '{32'h11, 32'h22, 32'h33};
    mbox_w_ready = 1'b0;
    apb_write(A_WDATA, 32'h11);
    apb_write(A_WDATA, 32'h22);
    apb_write(A_DONE, 32'h0);
    apb_write(A_WDATA, 32'h33);
    apb_read(A_STATUS, d);
    checks++;
    if (d[23:16] !== 8'd3) begin failures++; $display("FAIL tx_level3: got %0d expected 3", d[23:16]); end
    @(negedge pclk);
    mbox_w_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({mbox_w_valid, mbox_w_done, mbox_w_dat} !== {2'b10, exp_w[i]}) begin
        failures++;
        $display("FAIL tx_beat%0d: valid=%b done=%b dat=%h expected valid=1 done=0 dat=%h",
                 i, mbox_w_valid, mbox_w_done, mbox_w_dat, exp_w[i]);
      end
      @(negedge pclk);
    end
    checks++;
    if ({mbox_w_valid, mbox_w_done} !== 2'b01) begin
      failures++;
      $display("FAIL tx_done_pulse: valid=%b done=%b expected valid=0 done=1", mbox_w_valid, mbox_w_done);
    end
    @(negedge pclk);
    checks++;
    if (mbox_w_done !== 1'b0) begin failures++; $display("FAIL tx_done_clear: got %b expected 0", mbox_w_done); end
    mbox_w_ready = 1'b0;
    apb_read(A_STATUS, d);
    checks++;
    if (d[23:16] !== 8'd0) begin failures++; $display("FAIL tx_level0: got %0d expected 0", d[23:16]); end
  endtask

  task automatic test_tx_overflow();
    logic [31:0] d;
    for (int i = 0; i < 9; i++) apb_write(A_WDATA, 32'h100 + i);
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0008_0020) begin failures++; $display("FAIL ovf_status: got %h expected 00080020", d); end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL ovf_pend: got %h expected 8", d); end
    checks++;
    if (irq_error !== 1'b0) begin failures++; $display("FAIL ovf_irq_masked: got %b expected 0", irq_error); end
    apb_write(A_INT_EN, 32'h8);
    @(negedge pclk);
    checks++;
    if (irq_error !== 1'b1) begin failures++; $display("FAIL ovf_irq_enabled: got %b expected 1", irq_error); end
    mbox_w_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      checks++;
      if ({mbox_w_valid, mbox_w_dat} !== {1'b1, 32'h100 + 32'(i)}) begin
        failures++;
        $display("FAIL ovf_drain%0d: valid=%b dat=%h expected valid=1 dat=%h",
                 i, mbox_w_valid, mbox_w_dat, 32'h100 + 32'(i));
      end
      @(negedge pclk);
    end
    checks++;
    if (mbox_w_valid !== 1'b0) begin failures++; $display("FAIL ovf_ninth_dropped: valid=%b expected 0", mbox_w_valid); end
    mbox_w_ready = 1'b0;
    apb_write(A_STATUS, 32'h20);
    apb_write(A_INT_PEND, 32'h8);
    apb_write(A_INT_EN, 32'h0);
    @(negedge pclk);
    checks++;
    if (irq_error !== 1'b0) begin failures++; $display("FAIL ovf_irq_cleared: got %b expected 0", irq_error); end
  endtask

  task automatic test_rx_empty_err();
    logic [31:0] d;
    apb_read(A_RDATA, d);
    checks++;
    if (d !== 32'h0) begin failures++; $display("FAIL rx_empty_data: got %h expected 0", d); end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h12) begin failures++; $display("FAIL rx_err_set: got %h expected 00000012", d); end
    apb_write(A_STATUS, 32'h10);
    apb_write(A_INT_PEND, 32'h8);
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rx_err_w1c: got %h expected 00000002", d); end
  endtask

  task automatic test_rx_stream();
    logic [31:0] d;
    logic [31:0] words [4] = '{32'hA1, 32'hB2C3, 32'hDEAD_BEEF, 32'h0000_0004};
    for (int i = 0; i < 4; i++) begin
      @(negedge pclk);
      mbox_r_valid = 1'b1; mbox_r_dat = words[i];
      #1;
      checks++;
      if (mbox_r_ready !== 1'b1) begin failures++; $display("FAIL rx_ready%0d: got %b expected 1", i, mbox_r_ready); end
    end
    @(negedge pclk);
    mbox_r_valid = 1'b0; mbox_r_done = 1'b1;
    @(negedge pclk);
    mbox_r_done = 1'b0;
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h0000_0403) begin failures++; $display("FAIL rx_status4: got %h expected 00000403", d); end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h1) begin failures++; $display("FAIL rx_avail_pend: got %h expected 1", d); end
    for (int i = 0; i < 4; i++) begin
      apb_read(A_RDATA, d);
      checks++;
      if (d !== words[i]) begin failures++; $display("FAIL rx_word%0d: got %h expected %h", i, d, words[i]); end
    end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rx_drained: got %h expected 00000002", d); end
    apb_write(A_INT_PEND, 32'h1);
  endtask

  task automatic test_abort_local();
    logic [31:0] d;
    apb_write(A_INT_EN, 32'h4);
    for (int i = 0; i < 3; i++) apb_write(A_WDATA, 32'h70 + i);
    apb_write(A_ABORT, 32'h0);
    #1;
    checks++;
    if ({mbox_w_abort, mbox_w_valid} !== 2'b10) begin
      failures++;
      $display("FAIL abort_start: abort=%b valid=%b expected abort=1 valid=0", mbox_w_abort, mbox_w_valid);
    end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h6) begin failures++; $display("FAIL abort_busy_status: got %h expected 00000006", d); end
    @(negedge pclk);
    mbox_r_abort = 1'b1;
    @(negedge pclk);
    mbox_r_abort = 1'b0;
    #1;
    checks++;
    if ({mbox_w_abort, irq_abort_done} !== 2'b00) begin
      failures++;
      $display("FAIL abort_ack_seen: abort=%b irq=%b expected 00", mbox_w_abort, irq_abort_done);
    end
    @(negedge pclk);
    checks++;
    if (irq_abort_done !== 1'b1) begin failures++; $display("FAIL abort_irq: got %b expected 1", irq_abort_done); end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'hA) begin failures++; $display("FAIL abort_ack_status: got %h expected 0000000a", d); end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL abort_done_pend: got %h expected 4", d); end
    apb_write(A_STATUS, 32'h8);
    apb_write(A_INT_PEND, 32'h4);
    apb_write(A_INT_EN, 32'h0);
  endtask

  task automatic test_abort_timeout();
    logic [31:0] d;
    int held = 0;
    apb_write(A_ABORT, 32'h0);
    while (mbox_w_abort === 1'b1 && held < 100) begin
      held++;
      @(negedge pclk);
    end
    checks++;
    if (held !== 16) begin failures++; $display("FAIL timeout_cycles: got %0d expected 16", held); end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h8) begin failures++; $display("FAIL timeout_pend: got %h expected 8", d); end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL timeout_status: got %h expected 00000002", d); end
    apb_write(A_INT_PEND, 32'h8);
  endtask

  task automatic test_remote_abort();
    logic [31:0] d;
    apb_write(A_WDATA, 32'h55);
    @(negedge pclk);
    mbox_r_abort = 1'b1;
    @(negedge pclk);
    mbox_r_abort = 1'b0;
    #1;
    checks++;
    if (mbox_w_abort !== 1'b1) begin failures++; $display("FAIL remote_ack_pulse: got %b expected 1", mbox_w_abort); end
    @(negedge pclk);
    checks++;
    if (mbox_w_abort !== 1'b0) begin failures++; $display("FAIL remote_ack_end: got %b expected 0", mbox_w_abort); end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL remote_flush_status: got %h expected 00000002", d); end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL remote_init_pend: got %h expected 2", d); end
    apb_write(A_INT_PEND, 32'h2);
  endtask

  task automatic test_coincident_abort();
    logic [31:0] d;
    int pulses = 0;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = A_ABORT; pwdata = '0;
    @(negedge pclk);
    penable = 1'b1; mbox_r_abort = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; mbox_r_abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 if (mbox_w_abort === 1'b1) pulses++;
      @(negedge pclk);
    end
    checks++;
    if (pulses !== 0) begin failures++; $display("FAIL coincident_no_ack: abort high %0d cycles expected 0", pulses); end
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'hA) begin failures++; $display("FAIL coincident_status: got %h expected 0000000a", d); end
    apb_read(A_INT_PEND, d);
    checks++;
    if (d !== 32'h4) begin failures++; $display("FAIL coincident_pend: got %h expected 4", d); end
    apb_write(A_STATUS, 32'h8);
    apb_write(A_INT_PEND, 32'h4);
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] d;
    apb_write(A_ABORT, 32'h0);
    #1;
    checks++;
    if (mbox_w_abort !== 1'b1) begin failures++; $display("FAIL rstwait_enter: got %b expected 1", mbox_w_abort); end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (mbox_w_abort !== 1'b0) begin failures++; $display("FAIL rstwait_async: got %b expected 0", mbox_w_abort); end
    @(negedge pclk);
    reset = 1'b0;
    apb_read(A_STATUS, d);
    checks++;
    if (d !== 32'h2) begin failures++; $display("FAIL rstwait_status: got %h expected 00000002", d); end
  endtask

  initial begin
    test_reset();
    test_tx_stream();
    test_tx_overflow();
    test_rx_empty_err();
    test_rx_stream();
    test_abort_local();
    test_abort_timeout();
    test_remote_abort();
    test_coincident_abort();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
